// File: rtl/fft_frame_source_if.sv
// Upstream sample stream into fft_frame_source: valid/ready handshake carrying
// one complex sample per transfer plus the per-frame inverse request.
interface fft_frame_source_if #(
  parameter int WIDTH = 24
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] s_i;
  logic             inverse;

  modport master (output s_valid, s_r, s_i, inverse, input s_ready);
  modport slave  (input s_valid, s_r, s_i, inverse, output s_ready);
endinterface

// File: rtl/fft_frame_source.sv
// Ping-pong frame buffer feeding the streaming FFT input port, with optional per-frame conjugation.
// Define FFT_SRC_BITREV_EN to stream each frame in bit-reversed address order.
module fft_frame_source #(
  parameter int WIDTH      = 24,
  parameter int POINT_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_frame_source_if.slave    src,
  output logic                 fft_valid,
  output logic [WIDTH-1:0]     fft_r,
  output logic [WIDTH-1:0]     fft_i,
  output logic                 fft_sof,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);
  localparam int N = 2 ** POINT_LOG2;

  typedef logic [POINT_LOG2-1:0] cnt_t;
  typedef enum logic {IDLE, STREAM} state_t;

  logic [2*WIDTH-1:0] mem [2*N];

  logic [1:0]  full_q, full_d;
  logic [1:0]  inv_q;
  logic        wr_bank;
  cnt_t        wr_cnt;
  logic        wr_en, wr_last;

  state_t      state_q, state_d;
  logic        rd_bank_q, rd_bank_d;
  cnt_t        rd_cnt_q, rd_cnt_d;
  logic        load, sof_d, free, ld_bank;
  cnt_t        ld_cnt, ld_addr;

  logic [WIDTH-1:0] ld_r, ld_i, ld_i_out;
  logic [WIDTH:0]   neg_i;

  // ---------------------------------------------------------------- write side
  assign src.s_ready = ~full_q[wr_bank];
  assign wr_en       = src.s_valid & src.s_ready;
  assign wr_last     = wr_en & (wr_cnt == '1);

  // NOTE: the sample store has no reset so it maps onto plain RAM; a bank is
  // never read before its FULL flag (which is reset) says it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_cnt}] <= {src.s_r, src.s_i};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      inv_q   <= '0;
    end else if (wr_en) begin
      if (wr_cnt == '0) inv_q[wr_bank] <= src.inverse;
      wr_cnt <= wr_cnt + cnt_t'(1);
      if (wr_last) wr_bank <= ~wr_bank;
    end
  end

  always_comb begin
    full_d = full_q;
    if (free)    full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank]   = 1'b1;
  end

  // ---------------------------------------------------------------- read FSM
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    load      = 1'b0;
    sof_d     = 1'b0;
    free      = 1'b0;
    ld_bank   = rd_bank_q;
    ld_cnt    = rd_cnt_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = STREAM;
          load     = 1'b1;
          sof_d    = 1'b1;
          ld_cnt   = '0;
          rd_cnt_d = cnt_t'(1);
        end
      end
      STREAM: begin
        if (rd_cnt_q != '0) begin
          load     = 1'b1;
          rd_cnt_d = rd_cnt_q + cnt_t'(1);
        end else begin
          // rd_cnt wrapped: sample N-1 went out last edge, release the bank
          free      = 1'b1;
          rd_bank_d = ~rd_bank_q;
          if (full_q[~rd_bank_q]) begin
            load     = 1'b1;
            sof_d    = 1'b1;
            ld_bank  = ~rd_bank_q;
            ld_cnt   = '0;
            rd_cnt_d = cnt_t'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FFT_SRC_BITREV_EN
  always_comb begin
    for (int b = 0; b < POINT_LOG2; b++) ld_addr[b] = ld_cnt[POINT_LOG2-1-b];
  end
`else
  assign ld_addr = ld_cnt;
`endif

  assign {ld_r, ld_i} = mem[{ld_bank, ld_addr}];

  // Only -(-2**(WIDTH-1)) can overflow, and only towards the positive limit.
  assign neg_i    = -{ld_i[WIDTH-1], ld_i};
  assign ld_i_out = !inv_q[ld_bank]             ? ld_i :
                    (neg_i[WIDTH] != neg_i[WIDTH-1]) ? {1'b0, {(WIDTH-1){1'b1}}} :
                                                  neg_i[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
      fft_valid <= 1'b0;
      fft_sof   <= 1'b0;
      fft_r     <= '0;
      fft_i     <= '0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      fft_valid <= load;
      fft_sof   <= sof_d;
      if (load) begin
        fft_r <= ld_r;
        fft_i <= ld_i_out;
      end
      if (free) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign busy = (|full_q) | (state_q == STREAM);

endmodule

// File: tb/tb_fft_frame_source.sv
// Self-checking bench for fft_frame_source: directed frame sequences, a conjugation
// table and randomized traffic, all compared against a frame-queue reference model.
module tb_fft_frame_source;
  localparam int WIDTH      = 24;
  localparam int POINT_LOG2 = 4;
  localparam int N          = 1 << POINT_LOG2;

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [2*WIDTH-1:0] smp_t;
  typedef struct packed {
    word_t in_r;
    word_t in_i;
    word_t exp_r;
    word_t exp_i;
  } conj_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fft_valid, fft_sof, busy;
  word_t       fft_r, fft_i;
  logic [15:0] frame_cnt;

  fft_frame_source_if #(.WIDTH(WIDTH)) s_if ();

  fft_frame_source #(.WIDTH(WIDTH), .POINT_LOG2(POINT_LOG2)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (s_if),
    .fft_valid (fft_valid),
    .fft_r     (fft_r),
    .fft_i     (fft_i),
    .fft_sof   (fft_sof),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: completed frames waiting or streaming, oldest first.
  smp_t        fq[$];
  bit          fq_inv[$];
  smp_t        cur[N];
  bit          cur_inv;
  int          cur_cnt;
  int          written, freed;
  bit          m_stream;
  int          m_pos;
  logic        m_valid, m_sof;
  word_t       m_r, m_i;
  logic [15:0] m_cnt;

  word_t cap_r[$];
  word_t cap_i[$];
  bit    cap_sof[$];
  bit    vhist[$];

  conj_vec_t tab[N];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rd_addr(int p);
    int a;
    a = p;
`ifdef FFT_SRC_BITREV_EN
    a = 0;
    for (int b = 0; b < POINT_LOG2; b++)
      if (((p >> b) & 1) != 0) a = a | (1 << (POINT_LOG2 - 1 - b));
`endif
    return a;
  endfunction

  function automatic word_t neg_sat(word_t v);
    longint x;
    x = -longint'($signed(v));
    if (x > longint'(2 ** (WIDTH - 1)) - 1) x = longint'(2 ** (WIDTH - 1)) - 1;
    return word_t'(x);
  endfunction

  function automatic bit exp_ready();
    return (written - freed) < 2;
  endfunction

  task automatic model_reset();
    fq.delete();
    fq_inv.delete();
    cur_cnt  = 0;
    written  = 0;
    freed    = 0;
    m_stream = 0;
    m_pos    = 0;
    m_valid  = 1'b0;
    m_sof    = 1'b0;
    m_r      = '0;
    m_i      = '0;
    m_cnt    = '0;
  endtask

  task automatic emit(int pos);
    smp_t s;
    s       = fq[rd_addr(pos)];
    m_valid = 1'b1;
    m_sof   = (pos == 0);
    m_r     = s[2*WIDTH-1:WIDTH];
    m_i     = fq_inv[0] ? neg_sat(s[WIDTH-1:0]) : s[WIDTH-1:0];
  endtask

  // One clock edge of the model. The reader only sees frames completed before
  // this edge, so it runs before the writer adds this edge's frame.
  task automatic model_edge(bit acc, word_t r, word_t i, bit inv);
    if (m_stream) begin
      if (m_pos < N) begin
        emit(m_pos);
        m_pos++;
      end else begin
        for (int k = 0; k < N; k++) void'(fq.pop_front());
        void'(fq_inv.pop_front());
        freed++;
        m_cnt = m_cnt + 16'd1;
        if (fq_inv.size() > 0) begin
          emit(0);
          m_pos = 1;
        end else begin
          m_stream = 0;
          m_valid  = 1'b0;
          m_sof    = 1'b0;
        end
      end
    end else if (fq_inv.size() > 0) begin
      m_stream = 1;
      emit(0);
      m_pos = 1;
    end
    if (acc) begin
      if (cur_cnt == 0) cur_inv = inv;
      cur[cur_cnt] = {r, i};
      cur_cnt++;
      if (cur_cnt == N) begin
        for (int k = 0; k < N; k++) fq.push_back(cur[k]);
        fq_inv.push_back(cur_inv);
        written++;
        cur_cnt = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("s_ready",   s_if.s_ready, exp_ready());
    check("fft_valid", fft_valid,    m_valid);
    check("fft_sof",   fft_sof,      m_sof);
    check("fft_r",     fft_r,        m_r);
    check("fft_i",     fft_i,        m_i);
    check("busy",      busy,         (written != freed) || m_stream);
    check("frame_cnt", frame_cnt,    m_cnt);
  endtask

  task automatic drive(bit v, word_t r, word_t i, bit inv);
    s_if.s_valid = v;
    s_if.s_r     = r;
    s_if.s_i     = i;
    s_if.inverse = inv;
  endtask

  task automatic step();
    bit acc;
    acc = s_if.s_valid && exp_ready();
    @(posedge clk);
    model_edge(acc, s_if.s_r, s_if.s_i, s_if.inverse);
    @(negedge clk);
    compare_all();
    vhist.push_back(fft_valid);
    if (fft_valid) begin
      cap_r.push_back(fft_r);
      cap_i.push_back(fft_i);
      cap_sof.push_back(fft_sof);
    end
  endtask

  task automatic idle(int n);
    drive(1'b0, '0, '0, 1'b0);
    repeat (n) step();
  endtask

  task automatic send(word_t r, word_t i, bit inv);
    int budget;
    budget = 200;
    drive(1'b0, '0, '0, 1'b0);
    while (!exp_ready() && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("send_wait_ready", s_if.s_ready, 1);
    drive(1'b1, r, i, inv);
    step();
  endtask

  task automatic clear_capture();
    cap_r.delete();
    cap_i.delete();
    cap_sof.delete();
    vhist.delete();
  endtask

  // Asynchronous assert checked 1 time unit later, before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    clear_capture();
  endtask

  initial begin
    int sofs, run, first, stale, pv;

    tab[0]  = '{24'h000005, 24'h000005, 24'h000005, 24'hFFFFFB};
    tab[1]  = '{24'h000101, 24'h800000, 24'h000101, 24'h7FFFFF};
    tab[2]  = '{24'h000102, 24'h7FFFFF, 24'h000102, 24'h800001};
    tab[3]  = '{24'h000103, 24'h000000, 24'h000103, 24'h000000};
    tab[4]  = '{24'h000104, 24'hFFFFFF, 24'h000104, 24'h000001};
    tab[5]  = '{24'h800000, 24'h000001, 24'h800000, 24'hFFFFFF};
    tab[6]  = '{24'h000106, 24'h800001, 24'h000106, 24'h7FFFFF};
    tab[7]  = '{24'h7FFFFF, 24'h400000, 24'h7FFFFF, 24'hC00000};
    tab[8]  = '{24'h000108, 24'hC00000, 24'h000108, 24'h400000};
    tab[9]  = '{24'h000109, 24'h123456, 24'h000109, 24'hEDCBAA};
    tab[10] = '{24'h00010A, 24'hFFFFFE, 24'h00010A, 24'h000002};
    tab[11] = '{24'h00010B, 24'h000010, 24'h00010B, 24'hFFFFF0};
    tab[12] = '{24'h00010C, 24'h7FFFFE, 24'h00010C, 24'h800002};
    tab[13] = '{24'h00010D, 24'h800002, 24'h00010D, 24'h7FFFFE};
    tab[14] = '{24'h00010E, 24'h0000FF, 24'h00010E, 24'hFFFF01};
    tab[15] = '{24'hABCDEF, 24'hABCDEF, 24'hABCDEF, 24'h543211};

    drive(1'b0, '0, '0, 1'b0);
    model_reset();

    // Reset mid-frame: 7 stale samples must never reach the output.
    do_reset();
    for (int k = 0; k < 7; k++) send(word_t'(24'h700 + k), 24'h55, 1'b0);
    do_reset();
    check("t1_ready_after_rst", s_if.s_ready, 1);
    check("t1_valid_after_rst", fft_valid, 0);
    for (int k = 0; k < N; k++) send(word_t'(24'h10 + k), '0, 1'b0);
    idle(30);
    stale = 0;
    foreach (cap_r[j]) if (cap_r[j] >= 24'h700 && cap_r[j] <= 24'h706) stale++;
    check("t1_samples", cap_r.size(), N);
    check("t1_stale", stale, 0);

    // Single frame: one-cycle latency, order, single sof, count 0->1.
    do_reset();
    check("t2_cnt_start", frame_cnt, 0);
    for (int k = 0; k < N; k++) send(word_t'(k), '0, 1'b0);
    check("t2_valid_at_accept", fft_valid, 0);
    idle(1);
    check("t2_latency_valid", fft_valid, 1);
    check("t2_latency_sof", fft_sof, 1);
    idle(25);
    check("t2_samples", cap_r.size(), N);
    if (cap_r.size() >= N)
      for (int p = 0; p < N; p++) begin
        check("t2_order", cap_r[p], rd_addr(p));
        check("t2_sof", cap_sof[p], p == 0);
      end
    check("t2_cnt", frame_cnt, 1);

    // Continuous input, 4 frames: first two frames leave with no valid gap.
    do_reset();
    for (int k = 0; k < 4 * N; k++) send(word_t'(k), word_t'(3 * k), 1'b0);
    idle(40);
    sofs = 0;
    foreach (cap_sof[j]) sofs += int'(cap_sof[j]);
    first = -1;
    foreach (vhist[j]) if (first < 0 && vhist[j]) first = j;
    run = 0;
    if (first >= 0)
      for (int j = first; j < first + 2 * N && j < vhist.size(); j++) run += int'(vhist[j]);
    check("t3_samples", cap_r.size(), 4 * N);
    check("t3_sofs", sofs, 4);
    check("t3_zero_gap_run", run, 2 * N);
    check("t3_cnt", frame_cnt, 4);

    // Backpressure: 32 samples in 32 cycles fill both banks.
    do_reset();
    for (int k = 0; k < 2 * N; k++) send(word_t'(k + 24'h40), '0, 1'b0);
    check("t4_ready_both_full", s_if.s_ready, 0);
    check("t4_last_out_valid", fft_valid, 1);
    check("t4_last_out_data", fft_r, 24'h40 + rd_addr(N - 1));
    idle(1);
    check("t4_ready_back", s_if.s_ready, 1);
    check("t4_second_sof", fft_sof, 1);
    idle(30);
    check("t4_cnt", frame_cnt, 2);

    // Conjugated frame from the table, then the same inputs with inverse=0.
    // inverse is toggled on later samples to show only sample 0 latches it.
    do_reset();
    for (int k = 0; k < N; k++) send(tab[k].in_r, tab[k].in_i, k == 0);
    for (int k = 0; k < N; k++) send(tab[k].in_r, tab[k].in_i, k != 0);
    idle(40);
    check("t5_samples", cap_i.size(), 2 * N);
    if (cap_i.size() >= 2 * N)
      for (int p = 0; p < N; p++) begin
        check("t5_conj_r",  cap_r[p],     tab[rd_addr(p)].exp_r);
        check("t5_conj_i",  cap_i[p],     tab[rd_addr(p)].exp_i);
        check("t5_plain_r", cap_r[N + p], tab[rd_addr(p)].in_r);
        check("t5_plain_i", cap_i[N + p], tab[rd_addr(p)].in_i);
      end

    // Counter wrap: preset to 0xFFFF, one more frame gives 0.
    do_reset();
    force dut.frame_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    check("t6_preset", frame_cnt, 16'hFFFF);
    for (int k = 0; k < N; k++) send(word_t'(k), word_t'(k), 1'b0);
    idle(30);
    check("t6_wrap", frame_cnt, 16'h0000);

    // Randomized traffic with varying input duty and one reset mid-run.
    do_reset();
    pv = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) pv = int'($urandom_range(20, 100));
      if (c == 2100) do_reset();
      drive(int'($urandom_range(1, 100)) <= pv, word_t'($urandom), word_t'($urandom),
            1'($urandom_range(0, 1)));
      step();
    end
    idle(60);
    check("rand_drained_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
